// File: rtl/mci_initiator_pkg.sv
// Types for the MCI initiator: sequencing states and the latched miss-service command.
package mci_initiator_pkg;

    import memory_controller_interface::*;

    typedef enum logic [2:0] {
        IDLE,
        WB_ISSUE,
        WB_WAIT,
        FILL_ISSUE,
        FILL_WAIT,
        RESP
    } mci_init_state_t;

    typedef struct packed {
        logic                       evict;
        logic [MCI_ADDR_LENGTH-1:0] evict_addr;
        logic [MCI_DATA_LENGTH-1:0] evict_data;
        logic                       fill;
        logic [MCI_ADDR_LENGTH-1:0] fill_addr;
    } mci_cmd_t;

    function automatic logic is_wait(input mci_init_state_t s);
        return (s == WB_WAIT) || (s == FILL_WAIT);
    endfunction

endpackage

// File: rtl/memory_controller_interface.sv
// MCI transport types shared by cache-side initiators and main memory models.
// A request is {valid, rw, addr, data}; a response is {ready, data}.
package memory_controller_interface;

    localparam int MCI_ADDR_LENGTH = 32;
    localparam int MCI_DATA_LENGTH = 64;

    typedef struct packed {
        logic                       valid;
        logic                       rw;
        logic [MCI_ADDR_LENGTH-1:0] addr;
        logic [MCI_DATA_LENGTH-1:0] data;
    } mci_request_t;

    typedef struct packed {
        logic                       ready;
        logic [MCI_DATA_LENGTH-1:0] data;
    } mci_response_t;

endpackage

// File: rtl/mci_timeout_counter.sv
// Wait-cycle counter: expired pulses on the enabled cycle where the count sits at limit-1.
// A zero limit never expires.
module mci_timeout_counter #(
    parameter int CNT_W = 7
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expired
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_limit;

    assign w_at_limit = (i_limit != '0) && (r_count == (i_limit - ONE));
    assign o_expired  = i_enable && w_at_limit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_at_limit) begin
            r_count <= r_count + ONE;
        end
    end

endmodule

// File: rtl/mci_initiator.sv
// Cache-side MCI master: runs an optional victim writeback then an optional block fill
// for one command at a time, returning fill data or a timeout error.
//
// state      | meaning
// IDLE       | ready for a command
// WB_ISSUE   | write request pulse for the victim
// WB_WAIT    | waiting for write ready or timeout
// FILL_ISSUE | read request pulse for the fill block
// FILL_WAIT  | waiting for read ready (data captured) or timeout
// RESP       | response held until the cache consumes it
module mci_initiator
    import memory_controller_interface::*;
    import mci_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic                       i_cmd_evict,
    input  logic [MCI_ADDR_LENGTH-1:0] i_cmd_evict_addr,
    input  logic [MCI_DATA_LENGTH-1:0] i_cmd_evict_data,
    input  logic                       i_cmd_fill,
    input  logic [MCI_ADDR_LENGTH-1:0] i_cmd_fill_addr,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [MCI_DATA_LENGTH-1:0] o_rsp_data,
    output logic                       o_rsp_error,
    output mci_request_t               mem_req,
    input  mci_response_t              mem_res
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    mci_init_state_t            r_state;
    mci_init_state_t            w_next_state;
    mci_cmd_t                   r_cmd;
    logic [MCI_DATA_LENGTH-1:0] r_rsp_data;
    logic                       r_rsp_error;
    logic                       w_accept;
    logic                       w_cnt_clear;
    logic                       w_cnt_enable;
    logic                       w_expired;

    assign w_accept     = (r_state == IDLE) && i_cmd_valid;
    assign w_cnt_clear  = (r_state == WB_ISSUE) || (r_state == FILL_ISSUE);
    assign w_cnt_enable = is_wait(r_state) && !mem_res.ready;

    mci_timeout_counter #(
        .CNT_W(CNT_W)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_enable),
        .i_limit  (LIMIT),
        .o_expired(w_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Ready wins over a same-cycle expiry because it is tested first.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (i_cmd_evict)     w_next_state = WB_ISSUE;
                    else if (i_cmd_fill) w_next_state = FILL_ISSUE;
                    else                 w_next_state = RESP;
                end
            end
            WB_ISSUE:   w_next_state = WB_WAIT;
            WB_WAIT: begin
                if (mem_res.ready)  w_next_state = r_cmd.fill ? FILL_ISSUE : RESP;
                else if (w_expired) w_next_state = RESP;
            end
            FILL_ISSUE: w_next_state = FILL_WAIT;
            FILL_WAIT: begin
                if (mem_res.ready || w_expired) w_next_state = RESP;
            end
            RESP: begin
                if (i_rsp_ready) w_next_state = IDLE;
            end
            default:    w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd       <= '0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
        end else if (w_accept) begin
            r_cmd.evict      <= i_cmd_evict;
            r_cmd.evict_addr <= i_cmd_evict_addr;
            r_cmd.evict_data <= i_cmd_evict_data;
            r_cmd.fill       <= i_cmd_fill;
            r_cmd.fill_addr  <= i_cmd_fill_addr;
            r_rsp_data       <= '0;
            r_rsp_error      <= 1'b0;
        end else if ((r_state == FILL_WAIT) && mem_res.ready) begin
            r_rsp_data <= mem_res.data;
        end else if (w_expired) begin
            r_rsp_error <= 1'b1;
        end else if ((r_state == RESP) && i_rsp_ready) begin
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
        end
    end

    always_comb begin
        o_cmd_ready = (r_state == IDLE);
        o_rsp_valid = (r_state == RESP);
        mem_req     = '0;
        case (r_state)
            WB_ISSUE, WB_WAIT: begin
                mem_req.valid = (r_state == WB_ISSUE);
                mem_req.rw    = 1'b1;
                mem_req.addr  = r_cmd.evict_addr;
                mem_req.data  = r_cmd.evict_data;
            end
            FILL_ISSUE, FILL_WAIT: begin
                mem_req.valid = (r_state == FILL_ISSUE);
                mem_req.rw    = 1'b0;
                mem_req.addr  = r_cmd.fill_addr;
            end
            default: ;
        endcase
    end

    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_error = r_rsp_error;

endmodule
